mips_if_bpu: RTL
================

// Module: mips_if_bpu
// PURPOSE
// - IF-stage static branch predictor / next-PC generator; consumes the decoded BJP info from the IF mini-decoder.
// - Produces prdt_taken/prdt_pc for the current fetch and stalls IF while a jr/jalr target register is read.
// - Owns the IF-side rs read port and jr/jalr dependency wait; the EX stage resolves and flushes on mispredict.
// PARAMETERS
// - RAS_DEPTH   4   return-address-stack entries, power of two >= 2; used only with MIPS_BPU_RAS_EN
// PORTS
// - clk          in   1                   core clock, all state on rising edge
// - rst_n        in   1                   asynchronous active-low reset
// - ir_valid     in   1                   fetched instruction in IF is valid this cycle
// - flush        in   1                   EX mispredict/exception flush; kills any BPU operation
// - pc_incr      in   `MIPS_ADDR_WIDTH    PC+4 of the fetched instruction
// - dec_j/dec_jal/dec_jr/dec_jalr/dec_bxx  in  1 each  decoded class (one-hot or none)
// - dec_j_imm    in   `MIPS_ADDR_WIDTH    absolute j/jal target
// - dec_b_imm    in   `MIPS_ADDR_WIDTH    sign-extended, word-shifted branch offset
// - dec_rs_idx   in   `MIPS_RFIDX_WIDTH   rs index of jr/jalr
// - rs_dep       in   1                   rs has an outstanding writer in ID/EX/MEM
// - rf_rs_ren    out  1                   regfile read strobe; data returns next cycle
// - rf_rs_ridx   out  `MIPS_RFIDX_WIDTH   regfile read index (registered dec_rs_idx)
// - rf_rs_rdata  in   `MIPS_ADDR_WIDTH    regfile read data, valid the cycle after rf_rs_ren
// - bpu_wait     out  1                   hold PC and IF instruction register
// - prdt_valid   out  1                   prdt_taken/prdt_pc valid this cycle
// - prdt_taken   out  1                   predicted taken
// - prdt_pc      out  `MIPS_ADDR_WIDTH    predicted next PC (pc_incr when not taken)
// BEHAVIOUR
// - Reset: state=IDLE; rf_rs_ren=0, rf_rs_ridx=0, bpu_wait=0, prdt_valid=0, prdt_taken=0; RAS empty.
// - j/jal: same cycle, taken, prdt_pc=dec_j_imm. bxx: BTFN, taken iff dec_b_imm[MSB]=1;
//   taken prdt_pc=pc_incr+dec_b_imm, modulo 2^ADDR_WIDTH. Other insts: not taken, prdt_pc=pc_incr.
// - No architectural delay slot: prdt_pc replaces pc_incr as next fetch address.
// - jr/jalr, rs_idx==0: same cycle, taken, prdt_pc=0, no read.
// - jr/jalr, rs_idx!=0, IDLE: rs_dep=1 -> WAIT_DEP; else rf_rs_ren=1 -> RD_RS. bpu_wait=1, prdt_valid=0.
// - WAIT_DEP: bpu_wait=1; hold while rs_dep; on rs_dep=0 assert rf_rs_ren -> RD_RS.
// - RD_RS: bpu_wait=0, prdt_valid=1, prdt_taken=1, prdt_pc=rf_rs_rdata -> IDLE. Min jr latency 1 extra cycle.
// - rf_rs_ridx latched on IDLE exit; stable in WAIT_DEP/RD_RS.
// - flush: any state -> IDLE next cycle; same-cycle prdt_valid=0, bpu_wait=0, rf_rs_ren=0; RAS not repaired.
// - flush wins over a simultaneous new ir_valid; ir_valid ignored outside IDLE; inputs held by IF during wait.
// - prdt_valid = ir_valid & ~flush in IDLE for all same-cycle cases.
// CONFIGURATION
// - MIPS_BPU_RAS_EN defined: circular RAS of RAS_DEPTH entries. jal/jalr (IDLE, prdt_valid path) push pc_incr.
//   jr with rs_idx==31 and RAS non-empty: pop, predict top in same cycle, no read/wait; empty -> read path.
//   jalr rs==31 non-empty: pop+push same cycle (top replaced, count unchanged). Push when full overwrites
//   oldest, count saturates at RAS_DEPTH. Pointer wraps modulo RAS_DEPTH. Reset and flush leave/clear as above.
// - Not defined: no RAS storage; every jr/jalr with rs!=0 uses the read path; RAS_DEPTH unused.
// STRUCTURE
// - mips_defines.v: `MIPS_BPU_ST_IDLE/WAIT_DEP/RD_RS 2-bit encodings, `MIPS_RA_IDX (5'd31).
// - Sub-module mips_if_ras (push/pop/top/empty/full), instantiated only under `ifdef MIPS_BPU_RAS_EN.
// - FSM and target adder in mips_if_bpu.
// TESTING
// - Reset mid-RD_RS: rst_n low -> bpu_wait=0, rf_rs_ren=0, prdt_valid=0 immediately (async).
// - bxx pc_incr=0x104, b_imm=0xFFFFFFF0 -> taken, prdt_pc=0xF4; b_imm=0x20 -> not taken, prdt_pc=0x104.
// - jr $8, rs_dep=1 for 3 cycles, rdata=0x400 -> bpu_wait 4 cycles total, then prdt_valid, prdt_pc=0x400.
// - jr $8 no dep, flush in RD_RS cycle -> prdt_valid=0, state IDLE next cycle, no prediction issued.
// - RAS_EN, DEPTH=4: 5 jal with pc_incr 0x10..0x50, then 5 jr $31 -> 0x50,0x40,0x30,0x20 same cycle; 5th reads regfile.
// - jal 0x00400000 at pc_incr=0x8 -> same cycle taken, prdt_pc=0x00400000, bpu_wait=0.

Source files
------------

// File: rtl/mips_if_bpu_pkg.sv
// ---------------------------------------------------------------------------
// mips_if_bpu_pkg
// Shared widths, fixed register indices, FSM state encoding and the branch
// target helper used by the IF-stage branch predictor (mips_if_bpu) and its
// optional return-address stack (mips_if_ras).
// ---------------------------------------------------------------------------
package mips_if_bpu_pkg;

    // Architectural address width and register-file index width.
    localparam int ADDR_WIDTH  = 32;
    localparam int RFIDX_WIDTH = 5;

    // $ra: the link register used by jal and by the usual "jr $31" return.
    localparam logic [RFIDX_WIDTH-1:0] RA_IDX = 5'd31;

    // Predictor FSM states; encodings are fixed so they can be observed in
    // waveforms and matched by external checkers.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_WAIT_DEP = 2'b01,
        ST_RD_RS    = 2'b10
    } bpu_state_e;

    // Conditional branch target: PC+4 plus the pre-shifted, sign-extended
    // offset, wrapping modulo 2^ADDR_WIDTH.
    function automatic logic [ADDR_WIDTH-1:0] f_bxx_target(
        input logic [ADDR_WIDTH-1:0] pc_incr,
        input logic [ADDR_WIDTH-1:0] b_imm
    );
        return pc_incr + b_imm;
    endfunction

endpackage

// File: rtl/mips_if_ras.sv
// ---------------------------------------------------------------------------
// mips_if_ras
// Circular return-address stack of RAS_DEPTH entries.  A push when full
// overwrites the oldest entry (the count saturates); a simultaneous
// push+pop replaces the top entry and leaves the count unchanged.  Only
// instantiated when MIPS_BPU_RAS_EN is defined.
//
// Ports
//   clk          in   core clock
//   rst_n        in   asynchronous active-low reset (stack emptied)
//   i_push       in   push i_push_data
//   i_pop        in   pop the top entry (ignored when empty)
//   i_push_data  in   return address to push
//   o_top        out  current top-of-stack entry
//   o_empty      out  stack holds no entries
//   o_full       out  stack holds RAS_DEPTH entries
// ---------------------------------------------------------------------------
module mips_if_ras
    import mips_if_bpu_pkg::*;
#(
    parameter int RAS_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_push,
    input  logic                  i_pop,
    input  logic [ADDR_WIDTH-1:0] i_push_data,
    output logic [ADDR_WIDTH-1:0] o_top,
    output logic                  o_empty,
    output logic                  o_full
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(RAS_DEPTH);

    logic [ADDR_WIDTH-1:0] r_mem [RAS_DEPTH];
    logic [PTR_W-1:0]      r_top_ptr;
    logic [PTR_W:0]        r_count;
    logic [PTR_W-1:0]      w_ptr_inc;

    // Depth is a power of two, so pointer arithmetic wraps naturally.
    assign w_ptr_inc = r_top_ptr + 1'b1;
    assign o_top     = r_mem[r_top_ptr];
    assign o_empty   = (r_count == {(PTR_W + 1){1'b0}});
    assign o_full    = (r_count == DEPTH_CNT);

    // Stack pointer, occupancy count and entry storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_top_ptr <= {PTR_W{1'b0}};
            r_count   <= {(PTR_W + 1){1'b0}};
            for (int i = 0; i < RAS_DEPTH; i++) begin
                r_mem[i] <= {ADDR_WIDTH{1'b0}};
            end
        end else begin
            if (i_push && i_pop) begin
                // jalr through $ra: return consumed and new link pushed.
                r_mem[r_top_ptr] <= i_push_data;
            end else if (i_push) begin
                r_top_ptr        <= w_ptr_inc;
                r_mem[w_ptr_inc] <= i_push_data;
                if (!o_full) begin
                    r_count <= r_count + 1'b1;
                end
            end else if (i_pop && !o_empty) begin
                r_top_ptr <= r_top_ptr - 1'b1;
                r_count   <= r_count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/mips_if_bpu.sv
// ---------------------------------------------------------------------------
// mips_if_bpu
// IF-stage static branch predictor and next-PC generator.
//   j/jal        : taken, target = dec_j_imm, same cycle.
//   bxx          : backward-taken/forward-not-taken on the offset sign.
//   jr/jalr $0   : taken to address 0, same cycle.
//   jr/jalr $rs  : IF stalls (bpu_wait) while the IF-side regfile port reads
//                  rs, first waiting for any outstanding writer (rs_dep).
//   others       : not taken, prdt_pc = pc_incr.
// EX resolves the branch and raises flush on mispredict, which returns the
// predictor to IDLE and kills any prediction in the same cycle.
//
// Optional feature (macro MIPS_BPU_RAS_EN): a return-address stack of
// RAS_DEPTH entries; jal/jalr push PC+4 and "jr/jalr $31" pops the predicted
// return address without touching the regfile.  With the macro undefined
// there is no stack and RAS_DEPTH is unused.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   ir_valid                    fetched instruction valid
//   flush                       EX flush, kills any BPU operation
//   pc_incr                     PC+4 of the fetched instruction
//   dec_j/jal/jr/jalr/bxx       decoded branch class (one-hot or none)
//   dec_j_imm, dec_b_imm        jump target / branch offset
//   dec_rs_idx, rs_dep          jr/jalr source register and its hazard
//   rf_rs_ren, rf_rs_ridx       regfile read strobe / index
//   rf_rs_rdata                 regfile data, the cycle after rf_rs_ren
//   bpu_wait                    hold PC and IF instruction register
//   prdt_valid/taken/pc         prediction for the current fetch
// ---------------------------------------------------------------------------
module mips_if_bpu
    import mips_if_bpu_pkg::*;
#(
    parameter int RAS_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ir_valid,
    input  logic                   flush,
    input  logic [ADDR_WIDTH-1:0]  pc_incr,
    input  logic                   dec_j,
    input  logic                   dec_jal,
    input  logic                   dec_jr,
    input  logic                   dec_jalr,
    input  logic                   dec_bxx,
    input  logic [ADDR_WIDTH-1:0]  dec_j_imm,
    input  logic [ADDR_WIDTH-1:0]  dec_b_imm,
    input  logic [RFIDX_WIDTH-1:0] dec_rs_idx,
    input  logic                   rs_dep,
    output logic                   rf_rs_ren,
    output logic [RFIDX_WIDTH-1:0] rf_rs_ridx,
    input  logic [ADDR_WIDTH-1:0]  rf_rs_rdata,
    output logic                   bpu_wait,
    output logic                   prdt_valid,
    output logic                   prdt_taken,
    output logic [ADDR_WIDTH-1:0]  prdt_pc
);

    bpu_state_e             r_state;
    bpu_state_e             w_state_nxt;
    logic [RFIDX_WIDTH-1:0] r_rs_ridx;
    logic                   w_ridx_load;

    logic                   w_jr_class;
    logic                   w_rs_zero;
    logic                   w_rs_is_ra;
    logic                   w_ras_hit;
    logic                   w_need_read;
    logic                   w_idle_fire;
    logic                   w_b_taken;
    logic [ADDR_WIDTH-1:0]  w_bxx_target;
    logic                   w_ras_empty;
    logic [ADDR_WIDTH-1:0]  w_ras_top;

    assign w_jr_class   = dec_jr | dec_jalr;
    assign w_rs_zero    = (dec_rs_idx == {RFIDX_WIDTH{1'b0}});
    assign w_rs_is_ra   = (dec_rs_idx == RA_IDX);
    // Return predicted from the stack: no regfile read and no stall.
    assign w_ras_hit    = w_jr_class & w_rs_is_ra & ~w_ras_empty;
    assign w_need_read  = w_jr_class & ~w_rs_zero & ~w_ras_hit;
    // Including rst_n keeps every output low while reset is asserted even
    // if IF still presents a valid jr.
    assign w_idle_fire  = (r_state == ST_IDLE) & ir_valid & ~flush & rst_n;
    assign w_b_taken    = dec_b_imm[ADDR_WIDTH-1];
    assign w_bxx_target = f_bxx_target(pc_incr, dec_b_imm);
    assign rf_rs_ridx   = r_rs_ridx;

`ifdef MIPS_BPU_RAS_EN
    logic w_ras_push;
    logic w_ras_pop;
    logic w_ras_full;

    // Only instructions predicted in the IDLE same-cycle path touch the stack.
    assign w_ras_push = w_idle_fire & ~w_need_read & (dec_jal | dec_jalr);
    assign w_ras_pop  = w_idle_fire & w_ras_hit;

    mips_if_ras #(
        .RAS_DEPTH   (RAS_DEPTH)
    ) u_ras (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_ras_push),
        .i_pop       (w_ras_pop),
        .i_push_data (pc_incr),
        .o_top       (w_ras_top),
        .o_empty     (w_ras_empty),
        .o_full      (w_ras_full)
    );
`else
    assign w_ras_empty = 1'b1;
    assign w_ras_top   = {ADDR_WIDTH{1'b0}};
`endif

    // Next-state decode and same-cycle prediction outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_ridx_load = 1'b0;
        rf_rs_ren   = 1'b0;
        bpu_wait    = 1'b0;
        prdt_valid  = 1'b0;
        prdt_taken  = 1'b0;
        prdt_pc     = pc_incr;
        case (r_state)
            ST_IDLE: begin
                if (w_idle_fire) begin
                    if (w_need_read) begin
                        // jr/jalr through a live register: stall IF.
                        bpu_wait    = 1'b1;
                        w_ridx_load = 1'b1;
                        if (rs_dep) begin
                            w_state_nxt = ST_WAIT_DEP;
                        end else begin
                            rf_rs_ren   = 1'b1;
                            w_state_nxt = ST_RD_RS;
                        end
                    end else begin
                        prdt_valid = 1'b1;
                        if (dec_j | dec_jal) begin
                            prdt_taken = 1'b1;
                            prdt_pc    = dec_j_imm;
                        end else if (dec_bxx) begin
                            prdt_taken = w_b_taken;
                            prdt_pc    = w_b_taken ? w_bxx_target : pc_incr;
                        end else if (w_jr_class) begin
                            // Either $0 (target 0) or a stack hit.
                            prdt_taken = 1'b1;
                            prdt_pc    = w_ras_hit ? w_ras_top : {ADDR_WIDTH{1'b0}};
                        end else begin
                            prdt_taken = 1'b0;
                        end
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT_DEP: begin
                if (flush) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    bpu_wait = 1'b1;
                    if (!rs_dep) begin
                        rf_rs_ren   = 1'b1;
                        w_state_nxt = ST_RD_RS;
                    end else begin
                        w_state_nxt = ST_WAIT_DEP;
                    end
                end
            end
            ST_RD_RS: begin
                w_state_nxt = ST_IDLE;
                if (flush) begin
                    prdt_valid = 1'b0;
                end else begin
                    prdt_valid = 1'b1;
                    prdt_taken = 1'b1;
                    prdt_pc    = rf_rs_rdata;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Read index captured when leaving IDLE; stable for WAIT_DEP and RD_RS.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rs_ridx <= {RFIDX_WIDTH{1'b0}};
        end else if (w_ridx_load) begin
            r_rs_ridx <= dec_rs_idx;
        end else begin
            r_rs_ridx <= r_rs_ridx;
        end
    end

endmodule
